regfile_scheduler: RTL and testbench

- Sequences the single write port of RegistersUnit between two requesters: the in-order WB stage, and a long-latency unit such as a multi-cycle mul/div or a late load.
- Keeps a pending-destination scoreboard and gives decode a hazard stall.
- Sits between the WB/long-latency units and the RegistersUnit write port (RUWr, Rd, DataWr).

---
 rtl/rf_sched_pkg.sv | 20 ++
 rtl/regfile_scheduler_scoreboard.sv | 51 +++++
 rtl/regfile_scheduler.sv | 165 ++++++++++++++++
 tb/tb_regfile_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_sched_pkg.sv
// Shared types and constants for the regfile write-port scheduler.
package rf_sched_pkg;

  localparam int XLEN_C = 32;
  localparam int AW_C   = 5;
  localparam logic [AW_C-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } sched_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_LL   = 2'd2
  } grant_src_t;

endpackage

// File: rtl/regfile_scheduler_scoreboard.sv
// Pending-destination scoreboard: one bit per architectural register, set on
// long-latency issue, cleared on its writeback; x0 is never marked pending.
module rf_scoreboard
  import rf_sched_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = AW_C
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] rd,
  output logic          hazard
);

  logic [NREG-1:0] pending_r;
  logic [NREG-1:0] pending_nxt_s;

  // Next pending vector; the set is applied after the clear so it wins.
  always_comb begin
    pending_nxt_s = pending_r;
    if (clr_en) begin
      pending_nxt_s[clr_idx] = 1'b0;
    end else begin
      pending_nxt_s = pending_r;
    end
    if (set_en) begin
      pending_nxt_s[set_idx] = 1'b1;
    end else begin
      pending_nxt_s[0] = 1'b0;
    end
    pending_nxt_s[0] = 1'b0;
  end

  // Pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= {NREG{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  assign hazard = pending_r[rs1] | pending_r[rs2] | pending_r[rd];

endmodule

// File: rtl/regfile_scheduler.sv
// Arbitrates the single regfile write port between WB and a long-latency unit
// and raises the decode hazard stall. Optional starvation guard: RF_STARVE_GUARD_EN.
module regfile_scheduler
  import rf_sched_pkg::*;
#(
  parameter int XLEN       = XLEN_C,
  parameter int NREG       = 32,
  parameter int AW         = AW_C,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ll_valid,
  output logic            ll_ready,
  input  logic [AW-1:0]   ll_rd,
  input  logic [XLEN-1:0] ll_data,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   dec_rs1,
  input  logic [AW-1:0]   dec_rs2,
  input  logic [AW-1:0]   dec_rd,
  output logic            dec_stall,
  output logic            wb_hold,
  output logic            RUWr,
  output logic [AW-1:0]   Rd,
  output logic [XLEN-1:0] DataWr
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("STARVE_MAX must be in 1..15");
  end

  sched_state_t state_r, state_nxt_s;
  logic [3:0]   cnt_r, cnt_nxt_s;
  grant_src_t   gnt_s;
  logic         in_force_s;
  logic         ll_xfer_s;
  logic         hazard_s;

  // Grant selection: WB wins unless the starvation guard is forcing a yield.
  always_comb begin
    gnt_s      = GNT_NONE;
    in_force_s = 1'b0;
`ifdef RF_STARVE_GUARD_EN
    in_force_s = (state_r == FORCE);
`endif
    if (in_force_s) begin
      gnt_s = ll_valid ? GNT_LL : GNT_NONE;
    end else if (wb_we) begin
      gnt_s = GNT_WB;
    end else if (ll_valid) begin
      gnt_s = GNT_LL;
    end else begin
      gnt_s = GNT_NONE;
    end
  end

  assign ll_xfer_s = (gnt_s == GNT_LL);

  // State and wait-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic: count how long a long-latency result has been blocked by WB.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (ll_valid && (gnt_s == GNT_WB)) begin
          state_nxt_s = WAIT;
          cnt_nxt_s   = 4'd1;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
        end
      end
      WAIT: begin
        if (ll_xfer_s) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
`ifdef RF_STARVE_GUARD_EN
        end else if (cnt_r == 4'(STARVE_MAX)) begin
          state_nxt_s = FORCE;
        end else begin
          cnt_nxt_s = cnt_r + 4'd1;
        end
`else
        end else if (cnt_r != 4'd15) begin
          cnt_nxt_s = cnt_r + 4'd1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
`endif
      end
      FORCE: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Write-port mux and handshake outputs, all forced low while in reset.
  always_comb begin
    RUWr     = 1'b0;
    Rd       = {AW{1'b0}};
    DataWr   = {XLEN{1'b0}};
    ll_ready = 1'b0;
    wb_hold  = 1'b0;
    if (!rst_n) begin
      wb_hold = 1'b0;
    end else begin
      case (gnt_s)
        GNT_WB: begin
          RUWr   = (wb_rd != REG_ZERO);
          Rd     = wb_rd;
          DataWr = wb_data;
        end
        GNT_LL: begin
          ll_ready = 1'b1;
          RUWr     = (ll_rd != REG_ZERO);
          Rd       = ll_rd;
          DataWr   = ll_data;
        end
        default: begin
          RUWr = 1'b0;
        end
      endcase
      wb_hold = in_force_s;
    end
  end

  rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (iss_valid && !hazard_s && (iss_rd != REG_ZERO)),
    .set_idx (iss_rd),
    .clr_en  (ll_xfer_s && (ll_rd != REG_ZERO)),
    .clr_idx (ll_rd),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .rd      (dec_rd),
    .hazard  (hazard_s)
  );

  assign dec_stall = rst_n & hazard_s;

endmodule

// File: tb/tb_regfile_scheduler.sv
// Self-checking bench for regfile_scheduler; expected regfile writes are queued
// at drive time and checked by a monitor whenever RUWr is seen high.
module tb_regfile_scheduler;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wb_we;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            ll_valid;
  logic            ll_ready;
  logic [AW-1:0]   ll_rd;
  logic [XLEN-1:0] ll_data;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic [AW-1:0]   dec_rs1, dec_rs2, dec_rd;
  logic            dec_stall;
  logic            wb_hold;
  logic            RUWr;
  logic [AW-1:0]   Rd;
  logic [XLEN-1:0] DataWr;

  int total = 0;
  int bad   = 0;
  logic [AW+XLEN-1:0] exp_q[$];
  logic [AW+XLEN-1:0] exp_w;

  regfile_scheduler #(.XLEN(XLEN), .NREG(32), .AW(AW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_stall(dec_stall), .wb_hold(wb_hold),
    .RUWr(RUWr), .Rd(Rd), .DataWr(DataWr)
  );

  always #5 clk = ~clk;

  // Write monitor: every regfile write must match the oldest expected one.
  always @(negedge clk) begin
    if (RUWr === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write", Rd, DataWr);
      end else begin
        exp_w = exp_q.pop_front();
        if ({Rd, DataWr} !== exp_w) begin
          bad++;
          $display("FAIL write_data: got rd=%0d data=%h, expected rd=%0d data=%h",
                   Rd, DataWr, exp_w[AW+XLEN-1:XLEN], exp_w[XLEN-1:0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    ll_valid = 1'b0; ll_rd = 5'd0; ll_data = 32'd0;
    iss_valid = 1'b0; iss_rd = 5'd0;
    dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
  endtask

  task automatic test_reset();
    cyc();
    rst_n = 1'b0;
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hA5A5A5A5;
    @(negedge clk);
    total++;
    if (RUWr !== 1'b0 || Rd !== 5'd0 || DataWr !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs: got RUWr=%b Rd=%0d DataWr=%h, expected 0/0/0", RUWr, Rd, DataWr);
    end
    cyc();
    rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);
    total++;
    if ({RUWr, ll_ready, dec_stall, wb_hold} !== 4'b0000) begin
      bad++;
      $display("FAIL idle_after_reset: got RUWr/ll_ready/dec_stall/wb_hold=%b, expected 0000",
               {RUWr, ll_ready, dec_stall, wb_hold});
    end
  endtask

  task automatic test_wb_write();
    cyc();
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEADBEEF;
    exp_q.push_back({5'd1, 32'hDEADBEEF});
    @(negedge clk);
    total++;
    if (RUWr !== 1'b1 || Rd !== 5'd1) begin
      bad++;
      $display("FAIL wb_write: got RUWr=%b Rd=%0d, expected 1/1", RUWr, Rd);
    end
    cyc();
    wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
    @(negedge clk);
    total++;
    if (RUWr !== 1'b0) begin
      bad++;
      $display("FAIL wb_x0: got RUWr=%b, expected 0", RUWr);
    end
    cyc();
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    iss_valid = 1'b1; iss_rd = 5'd5;
    @(negedge clk);
    total++;
    if (dec_stall !== 1'b0) begin
      bad++;
      $display("FAIL sb_pre_issue: got dec_stall=%b, expected 0", dec_stall);
    end
    cyc();
    iss_valid = 1'b0; dec_rs2 = 5'd5;
    @(negedge clk);
    total++;
    if (dec_stall !== 1'b1) begin
      bad++;
      $display("FAIL sb_stall: got dec_stall=%b, expected 1", dec_stall);
    end
    cyc();
    ll_valid = 1'b1; ll_rd = 5'd5; ll_data = 32'h12345678;
    exp_q.push_back({5'd5, 32'h12345678});
    @(negedge clk);
    total++;
    if (ll_ready !== 1'b1 || RUWr !== 1'b1 || Rd !== 5'd5 || dec_stall !== 1'b1) begin
      bad++;
      $display("FAIL sb_ll_write: got ll_ready=%b RUWr=%b Rd=%0d dec_stall=%b, expected 1/1/5/1",
               ll_ready, RUWr, Rd, dec_stall);
    end
    cyc();
    ll_valid = 1'b0;
    @(negedge clk);
    total++;
    if (dec_stall !== 1'b0) begin
      bad++;
      $display("FAIL sb_unstall: got dec_stall=%b, expected 0", dec_stall);
    end
    cyc();
    idle_inputs();
  endtask

  task automatic test_conflict();
    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'h0000AAAA;
    ll_valid = 1'b1; ll_rd = 5'd6; ll_data = 32'h0000BBBB;
    exp_q.push_back({5'd2, 32'h0000AAAA});
    @(negedge clk);
    total++;
    if (ll_ready !== 1'b0 || Rd !== 5'd2) begin
      bad++;
      $display("FAIL conflict_wb: got ll_ready=%b Rd=%0d, expected 0/2", ll_ready, Rd);
    end
    cyc();
    wb_we = 1'b0;
    exp_q.push_back({5'd6, 32'h0000BBBB});
    @(negedge clk);
    total++;
    if (ll_ready !== 1'b1 || Rd !== 5'd6) begin
      bad++;
      $display("FAIL conflict_ll: got ll_ready=%b Rd=%0d, expected 1/6", ll_ready, Rd);
    end
    cyc();
    idle_inputs();
  endtask

  task automatic test_starve();
    logic ll_on;
    logic guard;
    logic exp_force;
`ifdef RF_STARVE_GUARD_EN
    guard = 1'b1;
`else
    guard = 1'b0;
`endif
    ll_on = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c != 0) cyc();
      wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h00000100 + 32'(c);
      ll_valid = ll_on; ll_rd = 5'd10; ll_data = 32'hC0FFEE00;
      exp_force = guard && (c == 5);
      if (exp_force) exp_q.push_back({5'd10, 32'hC0FFEE00});
      else           exp_q.push_back({5'd9, 32'h00000100 + 32'(c)});
      @(negedge clk);
      total++;
      if (wb_hold !== exp_force || ll_ready !== exp_force) begin
        bad++;
        $display("FAIL starve_c%0d: got wb_hold=%b ll_ready=%b, expected %b/%b",
                 c, wb_hold, ll_ready, exp_force, exp_force);
      end
      if (exp_force) ll_on = 1'b0;
    end
    cyc();
    wb_we = 1'b0; ll_valid = ll_on;
    if (ll_on) exp_q.push_back({5'd10, 32'hC0FFEE00});
    @(negedge clk);
    total++;
    if (ll_ready !== ll_on || wb_hold !== 1'b0) begin
      bad++;
      $display("FAIL starve_release: got ll_ready=%b wb_hold=%b, expected %b/0", ll_ready, wb_hold, ll_on);
    end
    cyc();
    idle_inputs();
  endtask

  task automatic test_edges();
    // Same-cycle set and clear of r7: set must win.
    iss_valid = 1'b1; iss_rd = 5'd7;
    cyc();
    ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h00000077;
    exp_q.push_back({5'd7, 32'h00000077});
    @(negedge clk);
    total++;
    if (ll_ready !== 1'b1) begin
      bad++;
      $display("FAIL setclr_ready: got ll_ready=%b, expected 1", ll_ready);
    end
    cyc();
    ll_valid = 1'b0; iss_rd = 5'd8; dec_rs1 = 5'd7;
    @(negedge clk);
    total++;
    if (dec_stall !== 1'b1) begin
      bad++;
      $display("FAIL setclr_wins: got dec_stall=%b, expected 1", dec_stall);
    end
    cyc();
    iss_valid = 1'b0; dec_rs1 = 5'd8;
    @(negedge clk);
    total++;
    if (dec_stall !== 1'b0) begin
      bad++;
      $display("FAIL issue_while_stalled: got dec_stall=%b, expected 0", dec_stall);
    end
    cyc();
    dec_rs1 = 5'd7; ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h00000777;
    exp_q.push_back({5'd7, 32'h00000777});
    cyc();
    ll_valid = 1'b0;
    @(negedge clk);
    total++;
    if (dec_stall !== 1'b0) begin
      bad++;
      $display("FAIL clear_r7: got dec_stall=%b, expected 0", dec_stall);
    end
    // Long-latency result to x0: handshaken but never written.
    cyc();
    dec_rs1 = 5'd0; ll_valid = 1'b1; ll_rd = 5'd0; ll_data = 32'h0BADF00D;
    @(negedge clk);
    total++;
    if (ll_ready !== 1'b1 || RUWr !== 1'b0) begin
      bad++;
      $display("FAIL ll_x0: got ll_ready=%b RUWr=%b, expected 1/0", ll_ready, RUWr);
    end
    // Reset pulse drops a pending destination.
    cyc();
    ll_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd3;
    cyc();
    iss_valid = 1'b0; dec_rd = 5'd3;
    @(negedge clk);
    total++;
    if (dec_stall !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_stall: got dec_stall=%b, expected 1", dec_stall);
    end
    cyc();
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (dec_stall !== 1'b0) begin
      bad++;
      $display("FAIL in_reset_stall: got dec_stall=%b, expected 0", dec_stall);
    end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (dec_stall !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_stall: got dec_stall=%b, expected 0", dec_stall);
    end
    cyc();
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    cyc();
    test_wb_write();
    test_scoreboard();
    test_conflict();
    test_starve();
    test_edges();
    cyc();
    cyc();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_writes: got %0d writes outstanding, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
